// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and the rest of the pipeline: ROM port,
// redirect/stall/trap requests coming in, and IF/ID + trap state going out.
interface fetch_stage_if #(
  parameter int ROM_AW = 8
);
  logic [ROM_AW-1:0] rom_addr_o;
  logic [31:0]       rom_data_i;
  logic              stall_i;
  logic              br_taken_i;
  logic [31:0]       br_target_i;
  logic              jmp_valid_i;
  logic [31:0]       jmp_target_i;
  logic              jr_valid_i;
  logic [31:0]       jr_target_i;
  logic              exc_i;
  logic              irq_i;
  logic              irq_block_i;
  logic [31:0]       pc_o;
  logic              ifid_valid_o;
  logic [31:0]       ifid_instr_o;
  logic [31:0]       ifid_pc_o;
  logic [31:0]       ifid_pc4_o;
  logic              trap_o;
  logic              trap_cause_o;
  logic [31:0]       epc_o;

  modport master (
    output rom_addr_o, pc_o, ifid_valid_o, ifid_instr_o, ifid_pc_o, ifid_pc4_o,
           trap_o, trap_cause_o, epc_o,
    input  rom_data_i, stall_i, br_taken_i, br_target_i, jmp_valid_i, jmp_target_i,
           jr_valid_i, jr_target_i, exc_i, irq_i, irq_block_i
  );

  modport slave (
    input  rom_addr_o, pc_o, ifid_valid_o, ifid_instr_o, ifid_pc_o, ifid_pc4_o,
           trap_o, trap_cause_o, epc_o,
    output rom_data_i, stall_i, br_taken_i, br_target_i, jmp_valid_i, jmp_target_i,
           jr_valid_i, jr_target_i, exc_i, irq_i, irq_block_i
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, prioritised redirects,
// interrupt/exception entry and exception PC.
module fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008,
  parameter int          ROM_AW    = 8,
  parameter logic [31:0] NOP       = 32'h0000_0000
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);

  logic [31:0] pc_r;
  logic        ifid_valid_r;
  logic [31:0] ifid_instr_r;
  logic [31:0] ifid_pc_r;
  logic [31:0] ifid_pc4_r;
  logic        trap_r;
  logic        trap_cause_r;
  logic [31:0] epc_r;
  logic [31:0] pc_inc_s;
  logic        irq_take_s;

  // Kernel bit 31 is never touched by the increment; carry out of bit 30 is dropped.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

  assign pc_inc_s   = pc_plus4(pc_r);
  assign irq_take_s = bus.irq_i & ~pc_r[31] & ~bus.irq_block_i;

  // PC / IF/ID / trap state update, highest-priority request first.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r         <= RESET_VEC;
      ifid_valid_r <= 1'b0;
      ifid_instr_r <= NOP;
      ifid_pc_r    <= 32'h0000_0000;
      ifid_pc4_r   <= 32'h0000_0000;
      trap_r       <= 1'b0;
      trap_cause_r <= 1'b0;
      epc_r        <= 32'h0000_0000;
    end else begin
      trap_r <= 1'b0;
      if (bus.br_taken_i) begin
        pc_r         <= bus.br_target_i;
        ifid_valid_r <= 1'b0;
        ifid_instr_r <= NOP;
      end else if (bus.stall_i) begin
        pc_r         <= pc_r;
        ifid_valid_r <= ifid_valid_r;
        ifid_instr_r <= ifid_instr_r;
      end else if (bus.exc_i) begin
        pc_r         <= XADR_VEC;
        ifid_valid_r <= 1'b0;
        ifid_instr_r <= NOP;
        epc_r        <= ifid_pc4_r;
        trap_r       <= 1'b1;
        trap_cause_r <= 1'b1;
      end else if (bus.jr_valid_i) begin
        pc_r         <= bus.jr_target_i;
        ifid_valid_r <= 1'b0;
        ifid_instr_r <= NOP;
      end else if (bus.jmp_valid_i) begin
        pc_r         <= bus.jmp_target_i;
        ifid_valid_r <= 1'b0;
        ifid_instr_r <= NOP;
      end else if (irq_take_s) begin
        // The instruction at PC was never fetched, so it is the resume point.
        pc_r         <= ILLOP_VEC;
        ifid_valid_r <= 1'b0;
        ifid_instr_r <= NOP;
        epc_r        <= pc_r;
        trap_r       <= 1'b1;
        trap_cause_r <= 1'b0;
      end else begin
        pc_r         <= pc_inc_s;
        ifid_valid_r <= 1'b1;
        ifid_instr_r <= bus.rom_data_i;
        ifid_pc_r    <= pc_r;
        ifid_pc4_r   <= pc_inc_s;
      end
    end
  end

  assign bus.rom_addr_o   = pc_r[ROM_AW+1:2];
  assign bus.pc_o         = pc_r;
  assign bus.ifid_valid_o = ifid_valid_r;
  assign bus.ifid_instr_o = ifid_instr_r;
  assign bus.ifid_pc_o    = ifid_pc_r;
  assign bus.ifid_pc4_o   = ifid_pc4_r;
  assign bus.trap_o       = trap_r;
  assign bus.trap_cause_o = trap_cause_r;
  assign bus.epc_o        = epc_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// request streams checked against a behavioural model of the fetch rules.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  fetch_stage_if #(.ROM_AW(8)) bus ();

  fetch_stage #(
    .RESET_VEC(32'h8000_0000), .ILLOP_VEC(32'h8000_0004), .XADR_VEC(32'h8000_0008),
    .ROM_AW(8), .NOP(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return 32'hC0DE_0000 ^ {22'd0, a, 2'b00};
  endfunction

  always_comb bus.rom_data_i = rom_word(bus.rom_addr_o);

  // Reference state
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_epc;
  logic        m_valid, m_trap, m_cause;

  // Apply current inputs to the model, advance one clock, sample after the edge.
  task automatic tick();
    logic [31:0] n_pc, n_instr, n_ifpc, n_ifpc4, n_epc;
    logic        n_valid, n_trap, n_cause, bubble;
    n_pc = m_pc; n_instr = m_instr; n_ifpc = m_ifpc; n_ifpc4 = m_ifpc4;
    n_epc = m_epc; n_valid = m_valid; n_trap = 1'b0; n_cause = m_cause;
    bubble = 1'b1;
    if (reset) begin
      n_pc = 32'h8000_0000; n_instr = 32'h0; n_ifpc = 32'h0; n_ifpc4 = 32'h0;
      n_epc = 32'h0; n_valid = 1'b0; n_cause = 1'b0; bubble = 1'b0;
    end else if (bus.br_taken_i) n_pc = bus.br_target_i;
    else if (bus.stall_i) bubble = 1'b0;
    else if (bus.exc_i) begin
      n_pc = 32'h8000_0008; n_epc = m_ifpc4; n_trap = 1'b1; n_cause = 1'b1;
    end else if (bus.jr_valid_i) n_pc = bus.jr_target_i;
    else if (bus.jmp_valid_i) n_pc = bus.jmp_target_i;
    else if (bus.irq_i && m_pc < 32'h8000_0000 && !bus.irq_block_i) begin
      n_pc = 32'h8000_0004; n_epc = m_pc; n_trap = 1'b1; n_cause = 1'b0;
    end else begin
      bubble = 1'b0;
      n_valid = 1'b1;
      n_instr = rom_word(m_pc[9:2]);
      n_ifpc = m_pc;
      n_ifpc4 = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
      n_pc = n_ifpc4;
    end
    if (bubble) begin
      n_valid = 1'b0; n_instr = 32'h0;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_ifpc = n_ifpc; m_ifpc4 = n_ifpc4;
    m_epc = n_epc; m_valid = n_valid; m_trap = n_trap; m_cause = n_cause;
  endtask

  task automatic idle_inputs();
    reset = 1'b0;
    bus.stall_i = 1'b0; bus.br_taken_i = 1'b0; bus.br_target_i = 32'h0;
    bus.jmp_valid_i = 1'b0; bus.jmp_target_i = 32'h0;
    bus.jr_valid_i = 1'b0; bus.jr_target_i = 32'h0;
    bus.exc_i = 1'b0; bus.irq_i = 1'b0; bus.irq_block_i = 1'b0;
  endtask

  task automatic branch_to(input logic [31:0] t);
    bus.br_taken_i = 1'b1; bus.br_target_i = t;
    tick();
    bus.br_taken_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({bus.pc_o, bus.ifid_valid_o, bus.ifid_instr_o, bus.epc_o, bus.trap_o, bus.trap_cause_o}
        !== {32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h valid=%b instr=%h epc=%h trap=%b cause=%b, required pc=80000000 others 0",
               bus.pc_o, bus.ifid_valid_o, bus.ifid_instr_o, bus.epc_o, bus.trap_o, bus.trap_cause_o);
    end
    n_checks++;
    if ({bus.ifid_pc_o, bus.ifid_pc4_o} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_ifid_pc: ifid_pc=%h pc4=%h, required 0/0", bus.ifid_pc_o, bus.ifid_pc4_o);
    end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if ({bus.pc_o, bus.ifid_valid_o, bus.ifid_instr_o, bus.ifid_pc_o}
          !== {32'h8000_0000 + 32'(4 * i), 1'b1, rom_word(8'(i - 1)), 32'h8000_0000 + 32'(4 * (i - 1))}) begin
        n_fail++;
        $display("FAIL free_run%0d: pc=%h valid=%b instr=%h ifid_pc=%h, required pc=%h valid=1 instr=%h",
                 i, bus.pc_o, bus.ifid_valid_o, bus.ifid_instr_o, bus.ifid_pc_o,
                 32'h8000_0000 + 32'(4 * i), rom_word(8'(i - 1)));
      end
    end
  endtask

  task automatic test_increment();
    branch_to(32'h0000_0FFC);
    tick();
    n_checks++;
    if ({bus.pc_o, bus.ifid_pc_o, bus.ifid_pc4_o, bus.ifid_valid_o} !== {32'h0000_1000, 32'h0000_0FFC, 32'h0000_1000, 1'b1}) begin
      n_fail++;
      $display("FAIL inc_ffc: pc=%h ifid_pc=%h pc4=%h valid=%b, required 00001000 00000ffc 00001000 1",
               bus.pc_o, bus.ifid_pc_o, bus.ifid_pc4_o, bus.ifid_valid_o);
    end
    branch_to(32'h7FFF_FFFC);
    tick();
    n_checks++;
    if ({bus.pc_o, bus.ifid_pc4_o} !== {32'h0000_0000, 32'h0000_0000}) begin
      n_fail++;
      $display("FAIL inc_wrap: pc=%h pc4=%h, required 00000000 00000000", bus.pc_o, bus.ifid_pc4_o);
    end
    branch_to(32'hFFFF_FFFC);
    tick();
    n_checks++;
    if (bus.pc_o !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL inc_kernel_wrap: pc=%h, required 80000000", bus.pc_o);
    end
  endtask

  task automatic test_stall_branch();
    logic [31:0] h_instr, h_ifpc;
    bus.stall_i = 1'b1;
    branch_to(32'h0000_0040);
    n_checks++;
    if ({bus.pc_o, bus.ifid_valid_o} !== {32'h0000_0040, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_branch: pc=%h valid=%b, required 00000040 0", bus.pc_o, bus.ifid_valid_o);
    end
    bus.stall_i = 1'b0;
    tick();
    h_instr = bus.ifid_instr_o; h_ifpc = bus.ifid_pc_o;
    bus.stall_i = 1'b1; bus.jmp_valid_i = 1'b1; bus.jmp_target_i = 32'h0000_0500;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.pc_o, bus.ifid_valid_o, bus.ifid_instr_o, bus.ifid_pc_o, bus.trap_o}
          !== {32'h0000_0044, 1'b1, rom_word(8'h10), 32'h0000_0040, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: pc=%h valid=%b instr=%h ifid_pc=%h trap=%b, required 00000044 1 %h 00000040 0",
                 i, bus.pc_o, bus.ifid_valid_o, bus.ifid_instr_o, bus.ifid_pc_o, bus.trap_o, rom_word(8'h10));
      end
    end
    bus.stall_i = 1'b0; bus.jmp_valid_i = 1'b0;
  endtask

  task automatic test_irq();
    branch_to(32'h0000_0020);
    bus.irq_i = 1'b1;
    tick();
    n_checks++;
    if ({bus.pc_o, bus.epc_o, bus.trap_o, bus.trap_cause_o} !== {32'h8000_0004, 32'h0000_0020, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL irq_entry: pc=%h epc=%h trap=%b cause=%b, required 80000004 00000020 1 0",
               bus.pc_o, bus.epc_o, bus.trap_o, bus.trap_cause_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.pc_o, bus.trap_o, bus.epc_o} !== {32'h8000_0008 + 32'(4 * i), 1'b0, 32'h0000_0020}) begin
        n_fail++;
        $display("FAIL irq_no_nest%0d: pc=%h trap=%b epc=%h, required %h 0 00000020",
                 i, bus.pc_o, bus.trap_o, bus.epc_o, 32'h8000_0008 + 32'(4 * i));
      end
    end
    bus.irq_i = 1'b0;
  endtask

  task automatic test_exc();
    branch_to(32'h0000_0100);
    tick();
    bus.exc_i = 1'b1; bus.jmp_valid_i = 1'b1; bus.jmp_target_i = 32'h0000_0200;
    tick();
    n_checks++;
    if ({bus.pc_o, bus.epc_o, bus.trap_o, bus.trap_cause_o, bus.ifid_valid_o}
        !== {32'h8000_0008, 32'h0000_0104, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL exc_entry: pc=%h epc=%h trap=%b cause=%b valid=%b, required 80000008 00000104 1 1 0",
               bus.pc_o, bus.epc_o, bus.trap_o, bus.trap_cause_o, bus.ifid_valid_o);
    end
    bus.exc_i = 1'b0; bus.jmp_valid_i = 1'b0;
  endtask

  task automatic test_reset_midstream();
    branch_to(32'h0000_0300);
    bus.stall_i = 1'b1; bus.irq_i = 1'b1; reset = 1'b1;
    tick();
    n_checks++;
    if ({bus.pc_o, bus.ifid_valid_o, bus.epc_o, bus.trap_o} !== {32'h8000_0000, 1'b0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_midstream: pc=%h valid=%b epc=%h trap=%b, required 80000000 0 00000000 0",
               bus.pc_o, bus.ifid_valid_o, bus.epc_o, bus.trap_o);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(79) == 0);
      bus.br_taken_i = ($urandom_range(7) == 0);
      bus.stall_i = ($urandom_range(4) == 0);
      bus.exc_i = ($urandom_range(11) == 0);
      bus.jr_valid_i = ($urandom_range(9) == 0);
      bus.jmp_valid_i = ($urandom_range(9) == 0);
      bus.irq_i = ($urandom_range(2) == 0);
      bus.irq_block_i = ($urandom_range(3) == 0);
      bus.br_target_i = $urandom() & 32'hFFFF_FFFC;
      bus.jr_target_i = $urandom() & 32'hFFFF_FFFC;
      bus.jmp_target_i = $urandom() & 32'h7FFF_FFFC;
      tick();
      n_checks++;
      if ({bus.pc_o, bus.rom_addr_o, bus.ifid_valid_o, bus.ifid_instr_o, bus.ifid_pc_o, bus.ifid_pc4_o}
          !== {m_pc, m_pc[9:2], m_valid, m_instr, m_ifpc, m_ifpc4}) begin
        n_fail++;
        $display("FAIL rand_pipe%0d: pc=%h addr=%h valid=%b instr=%h ifid_pc=%h pc4=%h, required %h %h %b %h %h %h",
                 i, bus.pc_o, bus.rom_addr_o, bus.ifid_valid_o, bus.ifid_instr_o, bus.ifid_pc_o, bus.ifid_pc4_o,
                 m_pc, m_pc[9:2], m_valid, m_instr, m_ifpc, m_ifpc4);
      end
      n_checks++;
      if ({bus.trap_o, bus.epc_o} !== {m_trap, m_epc} || (m_trap && bus.trap_cause_o !== m_cause)) begin
        n_fail++;
        $display("FAIL rand_trap%0d: trap=%b cause=%b epc=%h, required %b %b %h",
                 i, bus.trap_o, bus.trap_cause_o, bus.epc_o, m_trap, m_cause, m_epc);
      end
    end
    idle_inputs();
  endtask

  initial begin
    m_pc = 32'h0; m_instr = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
    m_epc = 32'h0; m_valid = 1'b0; m_trap = 1'b0; m_cause = 1'b0;
    idle_inputs();
    test_reset();
    test_increment();
    test_stall_branch();
    test_irq();
    test_exc();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
